// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle RV32I control FSM.
// Holds the state encoding, opcodes, ALU class codes, mux select codes and the
// word-sized MemOp used outside memory states.
package multicycle_control_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_ITYPE = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_PASSB = 3'b100;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [F3_W-1:0] MEMOP_WORD = 3'b010;

endpackage

// File: rtl/multicycle_control_fsm_branch_cond.sv
// Branch-taken decode from funct3 and the ALU compare flags.
// Ports: i_funct3 (branch kind), i_zero / i_alub31 / i_cout (flags of rs1-rs2),
//        o_taken_c (combinational taken).
module multicycle_control_fsm_branch_cond
  import multicycle_control_fsm_pkg::*;
(
  input  logic [F3_W-1:0] i_funct3,
  input  logic            i_zero,
  input  logic            i_alub31,
  input  logic            i_cout,
  output logic            o_taken_c
);

  // Cout=1 means rs1 >= rs2 unsigned, so BLTU is !Cout and BGEU is Cout.
  always_comb begin
    o_taken_c = 1'b0;
    case (i_funct3)
      3'b000:  o_taken_c = i_zero;
      3'b001:  o_taken_c = !i_zero;
      3'b100:  o_taken_c = i_alub31;
      3'b101:  o_taken_c = !i_alub31;
      3'b110:  o_taken_c = !i_cout;
      3'b111:  o_taken_c = i_cout;
      default: o_taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of a multicycle RV32I CPU: sequences fetch, decode,
// execute, memory and writeback and drives all datapath enables/selects.
// Inputs : clk, rst (async active-low), op, funct3, Zero, ALUb31, Cout.
// Outputs: PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite, ALUop,
//          ResultSrc, ALUSrcA, ALUSrcB, JALR_LSB, MemOp (decoded from state).
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [F3_W-1:0]    funct3,
  input  logic               Zero,
  input  logic               ALUb31,
  input  logic               Cout,
  output logic               PCUpdate,
  output logic               Branch,
  output logic               AddrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [SEL_W-1:0]   ResultSrc,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic               JALR_LSB,
  output logic [F3_W-1:0]    MemOp
);

  state_t state;
  state_t w_next;
  logic   w_taken;

  multicycle_control_fsm_branch_cond u_branch_cond (
    .i_funct3  (funct3),
    .i_zero    (Zero),
    .i_alub31  (ALUb31),
    .i_cout    (Cout),
    .o_taken_c (w_taken)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next    = S_FETCH;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    AddrSrc   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUop     = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    JALR_LSB  = 1'b0;
    MemOp     = MEMOP_WORD;

    case (state)
      S_FETCH: begin
        w_next    = S_DECODE;
        IRWrite   = 1'b1;
        PCUpdate  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        MemOp   = funct3;
      end
      S_MEMREAD: begin
        w_next  = S_MEMWB;
        AddrSrc = 1'b1;
        MemOp   = funct3;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        MemOp     = funct3;
      end
      S_MEMWRITE: begin
        AddrSrc  = 1'b1;
        MemWrite = 1'b1;
        MemOp    = funct3;
      end
      S_EXECR: begin
        w_next  = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUop   = ALUOP_RTYPE;
      end
      S_EXECI: begin
        w_next  = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALUOP_ITYPE;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUop   = ALUOP_SUB;
        Branch  = w_taken;
      end
      S_JALR: begin
        w_next  = S_JAL;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      // Shared by JAL and JALR: link value PC+4, PC loaded from ALUOut.
      S_JAL: begin
        w_next   = S_ALUWB;
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
        JALR_LSB = (op == OP_JALR);
      end
      S_LUI: begin
        w_next  = S_ALUWB;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALUOP_PASSB;
      end
      S_AUIPC: begin
        w_next  = S_ALUWB;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      default: w_next = S_FETCH;
    endcase

    // Enables stay quiet while reset is held even though state reads FETCH.
    if (!rst) begin
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the stimulus pushes the expected
// per-cycle output vector, the monitor pops and compares on every falling edge.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcu;
    logic       br;
    logic       addr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [2:0] aluop;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       lsb;
    logic [2:0] memop;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       ALUb31;
  logic       Cout;
  logic       PCUpdate;
  logic       Branch;
  logic       AddrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [2:0] ALUop;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       JALR_LSB;
  logic [2:0] MemOp;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  multicycle_control_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct3    (funct3),
    .Zero      (Zero),
    .ALUb31    (ALUb31),
    .Cout      (Cout),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .AddrSrc   (AddrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ALUop     (ALUop),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .JALR_LSB  (JALR_LSB),
    .MemOp     (MemOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t actual_obs();
    obs_t a;
    a = {4'(dut.state), PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite,
         ALUop, ResultSrc, ALUSrcA, ALUSrcB, JALR_LSB, MemOp};
    return a;
  endfunction

  // Hand-written output table, one entry per state.
  function automatic obs_t exp_obs(input logic [3:0] st, input logic [6:0] o,
                                   input logic [2:0] f3, input logic br,
                                   input logic rn);
    obs_t e;
    e       = '0;
    e.st    = st;
    e.memop = 3'b010;
    case (st)
      4'd0:  begin e.irw = 1'b1; e.pcu = 1'b1; e.sb = 2'b10; e.res = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; e.memop = f3; end
      4'd3:  begin e.addr = 1'b1; e.memop = f3; end
      4'd4:  begin e.res = 2'b01; e.rw = 1'b1; e.memop = f3; end
      4'd5:  begin e.addr = 1'b1; e.mw = 1'b1; e.memop = f3; end
      4'd6:  begin e.sa = 2'b10; e.aluop = 3'b010; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aluop = 3'b011; end
      4'd8:  begin e.rw = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.aluop = 3'b001; e.br = br; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcu = 1'b1; e.lsb = (o == 7'b1100111); end
      4'd11: begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd12: begin e.sb = 2'b01; e.aluop = 3'b100; end
      4'd13: begin e.sa = 2'b01; e.sb = 2'b01; end
      default: ;
    endcase
    if (!rn) begin
      e.pcu = 1'b0;
      e.irw = 1'b0;
    end
    return e;
  endfunction

  // Monitor: the FSM presents a fresh output vector every cycle.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual_obs();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_st%0d at %0t: got %06h expected %06h", e.st, $time, a, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction; seq lists the expected states, first in the top nibble.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic z, input logic b31, input logic c,
                           input logic br, input logic [23:0] seq, input int n);
    logic [3:0] st;
    op     = o;
    funct3 = f3;
    Zero   = z;
    ALUb31 = b31;
    Cout   = c;
    for (int i = 0; i < n; i++) begin
      st = seq[4*(n-1-i) +: 4];
      exp_q.push_back(exp_obs(st, o, f3, br, rst));
      step();
    end
  endtask

  initial begin
    rst    = 1'b0;
    op     = 7'b0000011;
    funct3 = 3'b100;
    Zero   = 1'b0;
    ALUb31 = 1'b0;
    Cout   = 1'b0;

    // Reset held: FETCH selects, enables off.
    step();
    exp_q.push_back(exp_obs(4'd0, op, funct3, 1'b0, 1'b0));
    step();
    exp_q.push_back(exp_obs(4'd0, op, funct3, 1'b0, 1'b0));
    step();
    rst = 1'b1;

    // Load (lbu): 0-1-2-3-4
    run_instr(7'b0000011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 24'h01234, 5);
    // Store (sh): 0-1-2-5
    run_instr(7'b0100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0125, 4);
    // R-type, I-type
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0168, 4);
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0178, 4);
    // JAL, JALR
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h01A8, 4);
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h01BA8, 5);
    // Branches: funct3, Zero, ALUb31, Cout -> taken
    run_instr(7'b1100011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 24'h019, 3);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 24'h019, 3);
    run_instr(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 24'h019, 3);
    run_instr(7'b1100011, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 24'h019, 3);
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 24'h019, 3);
    run_instr(7'b1100011, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 24'h019, 3);
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 24'h019, 3);
    run_instr(7'b1100011, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 24'h019, 3);
    run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 24'h019, 3);
    run_instr(7'b1100011, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 24'h019, 3);
    run_instr(7'b1100011, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 24'h019, 3);
    // LUI, AUIPC, illegal opcode
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h01C8, 4);
    run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h01D8, 4);
    run_instr(7'b0000000, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 24'h01, 2);

    // Store interrupted by reset in MEMWRITE.
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 24'h012, 3);
    exp_q.push_back(exp_obs(4'd5, op, funct3, 1'b0, 1'b1));
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (4'(dut.state) !== 4'd0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d MemWrite=%b expected state=0 MemWrite=0",
               4'(dut.state), MemWrite);
    end
    step();
    exp_q.push_back(exp_obs(4'd0, op, funct3, 1'b0, 1'b0));
    step();
    rst = 1'b1;

    // Recovery after reset: R-type again, then final FETCH.
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0168, 4);
    exp_q.push_back(exp_obs(4'd0, 7'b0110011, 3'b000, 1'b0, 1'b1));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for a multicycle RV32I CPU. Sequences fetch, decode, execute, memory and writeback steps for each instruction class.
- Drives every datapath enable and mux select.
- Sits in the control unit beside the ALU decoder. The datapath supplies the opcode, funct3 and ALU flags.

Parameters:
- None. State, opcode and select encodings are fixed constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- op  in  7  instruction opcode (instr[6:0])
- funct3  in  3  instruction funct3
- Zero  in  1  ALU result == 0
- ALUb31  in  1  signed less-than flag from the datapath (overflow-corrected)
- Cout  in  1  ALU carry out of a−b; 1 means a ≥ b unsigned
- PCUpdate  out  1  unconditional PC write
- Branch  out  1  branch taken (PC write this cycle)
- AddrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register / OldPC load
- RegWrite  out  1  register file write enable
- ALUop  out  3  ALU class: 000 add, 001 sub/compare, 010 R-type, 011 I-type, 100 pass B
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4
- JALR_LSB  out  1  clear bit 0 of the PC-bound result
- MemOp  out  3  access size/sign for the memory unit

Behaviour:
- Register `state` is 4 bits and is probed by benches. Encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13
- Reset:
  - rst low forces state = FETCH asynchronously, including mid-instruction.
  - While rst is low, PCUpdate, Branch, MemWrite, IRWrite and RegWrite are 0; all selects take their FETCH values.
- Transitions (one state per clock):
  - FETCH → DECODE
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100111 → JALR
    - 1100011 → BRANCH
    - 0110111 → LUI
    - 0010111 → AUIPC
    - any other opcode → FETCH (treated as a NOP)
  - MEMADR → MEMREAD for a load, MEMWRITE for a store
  - MEMREAD → MEMWB
  - EXECR, EXECI, LUI, AUIPC → ALUWB
  - JALR → JAL
  - JAL → ALUWB
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH
- Outputs are Moore, except Branch (flags) and JALR_LSB (op). Signals not listed are 0 or 00.
  - FETCH: AddrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUop=000, ResultSrc=10, PCUpdate=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUop=000 (branch/JAL target into ALUOut)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUop=000
  - MEMREAD: ResultSrc=00, AddrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: ResultSrc=00, AddrSrc=1, MemWrite=1
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUop=010
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUop=011
  - ALUWB: ResultSrc=00, RegWrite=1
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUop=001, ResultSrc=00, Branch=condition
  - JALR: ALUSrcA=10, ALUSrcB=01, ALUop=000 (target into ALUOut)
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUop=000, ResultSrc=00, PCUpdate=1, JALR_LSB=(op==1100111)
  - LUI: ALUSrcB=01, ALUop=100
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ALUop=000
- Branch condition by funct3:
  - 000: Zero; 001: !Zero
  - 100: ALUb31; 101: !ALUb31
  - 110: !Cout; 111: Cout
  - 010/011: 0
- MemOp = funct3 in MEMADR, MEMREAD, MEMWB and MEMWRITE; 3'b010 (word) in every other state.
- Instruction latency in cycles:
  - load 5; store 4; R-type, I-type, JAL, LUI and AUIPC 4
  - JALR 5; branch 3

Decomposition:
- Package holds the state enum, opcode constants, the ALUop / ResultSrc / ALUSrcA / ALUSrcB codes and the MemOp word constant.
- One sub-module is natural: branch_cond (funct3, Zero, ALUb31, Cout → taken).

Test Plan:
- Reset held, then released with op=0000011: state goes 0 → 1 → 2 → 3 → 4 → 0. RegWrite=1 and ResultSrc=01 only in MEMWB; MemOp=funct3 during memory states.
- op=0100011: states 0 → 1 → 2 → 5 → 0. MemWrite=1, AddrSrc=1 exactly one cycle. Asserting rst low mid-MEMWRITE returns to FETCH immediately with MemWrite=0.
- op=0110011, then op=0010011: 0 → 1 → 6 → 8 → 0 with ALUop=010; 0 → 1 → 7 → 8 → 0 with ALUop=011, ALUSrcB=01.
- op=1101111: 0 → 1 → 10 → 8, with PCUpdate=1 and JALR_LSB=0 in state 10. op=1100111: 0 → 1 → 11 → 10 → 8, with JALR_LSB=1 in state 10.
- op=1100011, funct3=000: Zero=1 in BRANCH gives Branch=1; Zero=0 gives Branch=0. funct3=110 with Cout=0 gives Branch=1. Next state is 0 in all cases.
- op=0110111: 0 → 1 → 12 → 8, ALUop=100. op=0010111: 0 → 1 → 13 → 8, ALUSrcA=01. Illegal op 0000000: 0 → 1 → 0, with no enables asserted in DECODE.
